// File: rtl/sys_bridge.sv
// sys_bridge: single-outstanding CPU-to-device bridge.
// The bridge decodes one CPU access into data memory (DM) or one of two timers,
// rejects illegal accesses, waits (bounded by TIMEOUT) for the device ready and
// answers the CPU with a one-cycle cpu_ready/cpu_err/cpu_rdata response.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   cpu_req/we/addr/wdata/byteen     CPU access request
//   cpu_rdata/ready/err              CPU response (registered)
//   dev_addr/wdata/byteen/we         shared device bus, latched at acceptance
//   dm_sel/t0_sel/t1_sel             one-cycle device strobes
//   dm/t0/t1 _ready, _rdata          device completion and read data
//   t0_irq, t1_irq, hw_int           timer interrupts, registered to the CP0 vector
module sys_bridge #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_byteen,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  output logic        cpu_err,
  output logic [31:0] dev_addr,
  output logic [31:0] dev_wdata,
  output logic [3:0]  dev_byteen,
  output logic        dev_we,
  output logic        dm_sel,
  output logic        t0_sel,
  output logic        t1_sel,
  input  logic        dm_ready,
  input  logic        t0_ready,
  input  logic        t1_ready,
  input  logic [31:0] dm_rdata,
  input  logic [31:0] t0_rdata,
  input  logic [31:0] t1_rdata,
  input  logic        t0_irq,
  input  logic        t1_irq,
  output logic [5:0]  hw_int
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;
  typedef enum logic [1:0] {TGT_DM = 2'd0, TGT_T0 = 2'd1, TGT_T1 = 2'd2, TGT_NONE = 2'd3} tgt_t;

  state_t             state_q;
  tgt_t               tgt_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [31:0]        cpu_rdata_q;
  logic               cpu_ready_q;
  logic               cpu_err_q;
  logic [31:0]        dev_addr_q;
  logic [31:0]        dev_wdata_q;
  logic [3:0]         dev_byteen_q;
  logic               dev_we_q;
  logic               dm_sel_q;
  logic               t0_sel_q;
  logic               t1_sel_q;
  logic [5:0]         hw_int_q;

  tgt_t               tgt_dec;
  logic               be_ok;
  logic               illegal_dec;
  logic               sel_ready;
  logic [31:0]        sel_rdata;

  // Address/byte-enable decode of the live CPU request (used only in IDLE).
  always_comb begin
    tgt_dec = TGT_NONE;
    if (cpu_addr < 32'h0000_3000)
      tgt_dec = TGT_DM;
    else if (cpu_addr >= 32'h0000_7F00 && cpu_addr <= 32'h0000_7F0B)
      tgt_dec = TGT_T0;
    else if (cpu_addr >= 32'h0000_7F10 && cpu_addr <= 32'h0000_7F1B)
      tgt_dec = TGT_T1;

    case (cpu_byteen)
      4'b1111, 4'b0011, 4'b1100,
      4'b0001, 4'b0010, 4'b0100, 4'b1000: be_ok = 1'b1;
      default:                            be_ok = 1'b0;
    endcase

    // Timers are word-only, and 0x7F08/0x7F18 (timer count) are read-only.
    illegal_dec = (tgt_dec == TGT_NONE) || !be_ok ||
                  ((tgt_dec == TGT_T0 || tgt_dec == TGT_T1) && cpu_byteen != 4'b1111) ||
                  (cpu_we && (cpu_addr == 32'h0000_7F08 || cpu_addr == 32'h0000_7F18));
  end

  // Only the latched target's ready/rdata is ever looked at.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = 32'h0;
    case (tgt_q)
      TGT_DM:  begin sel_ready = dm_ready; sel_rdata = dm_rdata; end
      TGT_T0:  begin sel_ready = t0_ready; sel_rdata = t0_rdata; end
      TGT_T1:  begin sel_ready = t1_ready; sel_rdata = t1_rdata; end
      default: begin sel_ready = 1'b0;     sel_rdata = 32'h0;    end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      tgt_q        <= TGT_NONE;
      cnt_q        <= '0;
      cpu_rdata_q  <= 32'h0;
      cpu_ready_q  <= 1'b0;
      cpu_err_q    <= 1'b0;
      dev_addr_q   <= 32'h0;
      dev_wdata_q  <= 32'h0;
      dev_byteen_q <= 4'h0;
      dev_we_q     <= 1'b0;
      dm_sel_q     <= 1'b0;
      t0_sel_q     <= 1'b0;
      t1_sel_q     <= 1'b0;
      hw_int_q     <= 6'h0;
    end else begin
      hw_int_q    <= {4'b0000, t1_irq, t0_irq};
      // Strobes and the response are single-cycle pulses by default.
      cpu_ready_q <= 1'b0;
      cpu_err_q   <= 1'b0;
      dm_sel_q    <= 1'b0;
      t0_sel_q    <= 1'b0;
      t1_sel_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cpu_req) begin
            dev_addr_q   <= cpu_addr;
            dev_wdata_q  <= cpu_wdata;
            dev_byteen_q <= cpu_byteen;
            dev_we_q     <= cpu_we;
            tgt_q        <= tgt_dec;
            if (illegal_dec) begin
              state_q     <= RESP;
              cpu_ready_q <= 1'b1;
              cpu_err_q   <= 1'b1;
              cpu_rdata_q <= 32'h0;
            end else begin
              state_q  <= WAIT;
              cnt_q    <= CNT_W'(1);
              dm_sel_q <= (tgt_dec == TGT_DM);
              t0_sel_q <= (tgt_dec == TGT_T0);
              t1_sel_q <= (tgt_dec == TGT_T1);
            end
          end
        end
        WAIT: begin
          if (sel_ready) begin
            state_q     <= RESP;
            cpu_ready_q <= 1'b1;
            cpu_err_q   <= 1'b0;
            cpu_rdata_q <= dev_we_q ? 32'h0 : sel_rdata;
          end else if (cnt_q == CNT_W'(TIMEOUT)) begin
            state_q     <= RESP;
            cpu_ready_q <= 1'b1;
            cpu_err_q   <= 1'b1;
            cpu_rdata_q <= 32'h0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RESP: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cpu_rdata  = cpu_rdata_q;
  assign cpu_ready  = cpu_ready_q;
  assign cpu_err    = cpu_err_q;
  assign dev_addr   = dev_addr_q;
  assign dev_wdata  = dev_wdata_q;
  assign dev_byteen = dev_byteen_q;
  assign dev_we     = dev_we_q;
  assign dm_sel     = dm_sel_q;
  assign t0_sel     = t0_sel_q;
  assign t1_sel     = t1_sel_q;
  assign hw_int     = hw_int_q;

endmodule

// File: tb/tb_sys_bridge.sv
// tb_sys_bridge: directed-vector bench for sys_bridge with hand-computed
// expected latencies, error flags, read data and strobe counts.
module tb_sys_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [3:0]  cpu_byteen;
  logic [31:0] cpu_rdata;
  logic        cpu_ready, cpu_err;
  logic [31:0] dev_addr, dev_wdata;
  logic [3:0]  dev_byteen;
  logic        dev_we;
  logic        dm_sel, t0_sel, t1_sel;
  logic        dm_ready, t0_ready, t1_ready;
  logic [31:0] dm_rdata, t0_rdata, t1_rdata;
  logic        t0_irq, t1_irq;
  logic [5:0]  hw_int;

  int n_tests = 0;
  int n_fail  = 0;

  sys_bridge #(.TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_byteen(cpu_byteen),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_err(cpu_err),
    .dev_addr(dev_addr), .dev_wdata(dev_wdata), .dev_byteen(dev_byteen), .dev_we(dev_we),
    .dm_sel(dm_sel), .t0_sel(t0_sel), .t1_sel(t1_sel),
    .dm_ready(dm_ready), .t0_ready(t0_ready), .t1_ready(t1_ready),
    .dm_rdata(dm_rdata), .t0_rdata(t0_rdata), .t1_rdata(t1_rdata),
    .t0_irq(t0_irq), .t1_irq(t1_irq), .hw_int(hw_int)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exceeded, got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One CPU access. dev selects which device answers (0 DM, 1 T0, 2 T1);
  // dly is the WAIT cycle (0 = strobe cycle) in which it answers, -1 never.
  // noise drives the other two readies high throughout; late keeps the
  // device ready high for two cycles after the response.
  task automatic run(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, input int dev, input int dly, input bit noise,
                     input logic [31:0] rd, input bit late,
                     output int lat, output int ns_dm, output int ns_t0, output int ns_t1,
                     output logic err, output logic [31:0] rdata);
    bit done = 1'b0;
    lat = 0; ns_dm = 0; ns_t0 = 0; ns_t1 = 0; err = 1'b0; rdata = 32'h0;
    dm_rdata = (dev == 0) ? rd : ~rd;
    t0_rdata = (dev == 1) ? rd : ~rd;
    t1_rdata = (dev == 2) ? rd : ~rd;
    cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_byteen = be; cpu_req = 1'b1;
    tick();
    cpu_req = 1'b0;
    // Scramble the CPU inputs: the bridge must be working from its latched copy.
    cpu_we = ~we; cpu_addr = 32'hFFFF_FFFF; cpu_wdata = ~wdata; cpu_byteen = 4'b0000;
    lat = 1;
    for (int c = 0; c < 40 && !done; c++) begin
      ns_dm += int'(dm_sel); ns_t0 += int'(t0_sel); ns_t1 += int'(t1_sel);
      if (cpu_ready) begin
        done  = 1'b1;
        err   = cpu_err;
        rdata = cpu_rdata;
      end else begin
        if (c == 0) begin
          check("hold_addr", dev_addr, addr);
          check("hold_wdata", dev_wdata, wdata);
          check("hold_we", {31'b0, dev_we}, {31'b0, we});
        end
        dm_ready = ((dev == 0) && (c == dly)) || (noise && dev != 0);
        t0_ready = ((dev == 1) && (c == dly)) || (noise && dev != 1);
        t1_ready = ((dev == 2) && (c == dly)) || (noise && dev != 2);
        tick();
        lat++;
      end
    end
    if (!done) check("ready_bound", {31'b0, cpu_ready}, 32'd1);
    dm_ready = late && dev == 0;
    t0_ready = late && dev == 1;
    t1_ready = late && dev == 2;
    tick();
    ns_dm += int'(dm_sel); ns_t0 += int'(t0_sel); ns_t1 += int'(t1_sel);
    check("ready_one_cycle", {31'b0, cpu_ready}, 32'd0);
    if (late) begin
      tick();
      check("late_ready_ignored", {31'b0, cpu_ready}, 32'd0);
    end
    dm_ready = 1'b0; t0_ready = 1'b0; t1_ready = 1'b0;
  endtask

  initial begin
    int lat, n0, n1, n2;
    logic e;
    logic [31:0] r;

    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    cpu_byteen = 4'h0; dm_ready = 1'b0; t0_ready = 1'b0; t1_ready = 1'b0;
    dm_rdata = 32'h0; t0_rdata = 32'h0; t1_rdata = 32'h0; t0_irq = 1'b0; t1_irq = 1'b0;
    tick(); tick(); tick();
    check("rst_ready", {31'b0, cpu_ready}, 32'd0);
    check("rst_err", {31'b0, cpu_err}, 32'd0);
    check("rst_rdata", cpu_rdata, 32'h0);
    check("rst_sel", {29'b0, dm_sel, t0_sel, t1_sel}, 32'd0);
    check("rst_dev_we", {31'b0, dev_we}, 32'd0);
    check("rst_dev_addr", dev_addr, 32'h0);
    check("rst_dev_wdata", dev_wdata, 32'h0);
    check("rst_dev_be", {28'b0, dev_byteen}, 32'd0);
    check("rst_hw_int", {26'b0, hw_int}, 32'd0);
    reset = 1'b0;
    tick();

    // DM load, ready in the strobe cycle.
    run(1'b0, 32'h0000_1004, 32'h0, 4'b1111, 0, 0, 1'b0, 32'hDEAD_BEEF, 1'b0, lat, n0, n1, n2, e, r);
    check("dm_ld_lat", 32'(lat), 32'd2);
    check("dm_ld_err", {31'b0, e}, 32'd0);
    check("dm_ld_rdata", r, 32'hDEAD_BEEF);
    check("dm_ld_sel", 32'(n0), 32'd1);
    check("dm_ld_other_sel", 32'(n1 + n2), 32'd0);

    // DM half-word load at the top of DM, ready three cycles into WAIT.
    run(1'b0, 32'h0000_2FFC, 32'h0, 4'b0011, 0, 3, 1'b0, 32'h1234_5678, 1'b0, lat, n0, n1, n2, e, r);
    check("dm_hw_lat", 32'(lat), 32'd5);
    check("dm_hw_err", {31'b0, e}, 32'd0);
    check("dm_hw_rdata", r, 32'h1234_5678);
    check("dm_hw_sel", 32'(n0), 32'd1);

    // Timer1 load that never completes: 15 WAIT cycles, then a bus error.
    run(1'b0, 32'h0000_7F14, 32'h0, 4'b1111, 2, -1, 1'b0, 32'h7777_7777, 1'b1, lat, n0, n1, n2, e, r);
    check("to_lat", 32'(lat), 32'd16);
    check("to_err", {31'b0, e}, 32'd1);
    check("to_rdata", r, 32'h0);
    check("to_sel", 32'(n2), 32'd1);

    // Store to read-only timer count register.
    run(1'b1, 32'h0000_7F08, 32'h1, 4'b1111, 1, 0, 1'b0, 32'h0, 1'b0, lat, n0, n1, n2, e, r);
    check("ro_st_lat", 32'(lat), 32'd1);
    check("ro_st_err", {31'b0, e}, 32'd1);
    check("ro_st_sel", 32'(n0 + n1 + n2), 32'd0);

    run(1'b0, 32'h0000_7F04, 32'h0, 4'b0001, 1, 0, 1'b0, 32'h0, 1'b0, lat, n0, n1, n2, e, r);
    check("t0_byte_lat", 32'(lat), 32'd1);
    check("t0_byte_err", {31'b0, e}, 32'd1);
    check("t0_byte_sel", 32'(n0 + n1 + n2), 32'd0);

    run(1'b0, 32'h0000_3000, 32'h0, 4'b1111, 0, 0, 1'b0, 32'h0, 1'b0, lat, n0, n1, n2, e, r);
    check("unmap_lat", 32'(lat), 32'd1);
    check("unmap_err", {31'b0, e}, 32'd1);
    check("unmap_sel", 32'(n0 + n1 + n2), 32'd0);

    // Timer0 load with the other devices' readies stuck high.
    run(1'b0, 32'h0000_7F00, 32'h0, 4'b1111, 1, 2, 1'b1, 32'hA5A5_0001, 1'b0, lat, n0, n1, n2, e, r);
    check("t0_noise_lat", 32'(lat), 32'd4);
    check("t0_noise_err", {31'b0, e}, 32'd0);
    check("t0_noise_rdata", r, 32'hA5A5_0001);
    check("t0_noise_sel", 32'(n1), 32'd1);
    check("t0_noise_other_sel", 32'(n0 + n2), 32'd0);

    // Timer1 store returns zero read data.
    run(1'b1, 32'h0000_7F10, 32'h0000_0042, 4'b1111, 2, 1, 1'b0, 32'hCAFE_F00D, 1'b0, lat, n0, n1, n2, e, r);
    check("t1_st_lat", 32'(lat), 32'd3);
    check("t1_st_err", {31'b0, e}, 32'd0);
    check("t1_st_rdata", r, 32'h0);
    check("t1_st_sel", 32'(n2), 32'd1);

    run(1'b0, 32'h0000_0100, 32'h0, 4'b0101, 0, 0, 1'b0, 32'h0, 1'b0, lat, n0, n1, n2, e, r);
    check("be_0101_err", {31'b0, e}, 32'd1);
    check("be_0101_sel", 32'(n0), 32'd0);
    run(1'b0, 32'h0000_0100, 32'h0, 4'b0000, 0, 0, 1'b0, 32'h0, 1'b0, lat, n0, n1, n2, e, r);
    check("be_0000_err", {31'b0, e}, 32'd1);
    check("be_0000_lat", 32'(lat), 32'd1);
    run(1'b1, 32'h0000_7F18, 32'h0, 4'b1111, 2, 0, 1'b0, 32'h0, 1'b0, lat, n0, n1, n2, e, r);
    check("ro_st1_err", {31'b0, e}, 32'd1);
    check("ro_st1_sel", 32'(n2), 32'd0);

    // Reset during WAIT of a DM store aborts it; a later ready is ignored.
    cpu_we = 1'b1; cpu_addr = 32'h0000_0200; cpu_wdata = 32'h0000_0055; cpu_byteen = 4'b1111;
    cpu_req = 1'b1;
    tick();
    cpu_req = 1'b0;
    check("abort_sel", {31'b0, dm_sel}, 32'd1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_ready", {31'b0, cpu_ready}, 32'd0);
    check("abort_dev_we", {31'b0, dev_we}, 32'd0);
    check("abort_dev_addr", dev_addr, 32'h0);
    dm_ready = 1'b1;
    tick();
    check("abort_late_rdy1", {31'b0, cpu_ready}, 32'd0);
    tick();
    check("abort_late_rdy2", {31'b0, cpu_ready}, 32'd0);
    dm_ready = 1'b0;
    run(1'b0, 32'h0000_0000, 32'h0, 4'b1111, 0, 0, 1'b0, 32'h0BAD_F00D, 1'b0, lat, n0, n1, n2, e, r);
    check("post_rst_lat", 32'(lat), 32'd2);
    check("post_rst_err", {31'b0, e}, 32'd0);
    check("post_rst_rdata", r, 32'h0BAD_F00D);

    // Interrupt pass-through while a DM access is waiting.
    cpu_we = 1'b0; cpu_addr = 32'h0000_0008; cpu_byteen = 4'b1111; cpu_req = 1'b1;
    dm_rdata = 32'h1122_3344;
    tick();
    cpu_req = 1'b0;
    check("irq_dm_sel", {31'b0, dm_sel}, 32'd1);
    t0_irq = 1'b1;
    tick();
    check("irq_hw_int", {26'b0, hw_int}, 32'd1);
    check("irq_busy", {31'b0, cpu_ready}, 32'd0);
    t0_irq = 1'b0;
    tick();
    check("irq_hw_int_clr", {26'b0, hw_int}, 32'd0);
    dm_ready = 1'b1;
    tick();
    dm_ready = 1'b0;
    check("irq_ready", {31'b0, cpu_ready}, 32'd1);
    check("irq_rdata", cpu_rdata, 32'h1122_3344);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
